bcd_down_timer: RTL
===================

// Module: bcd_down_timer
// PURPOSE
//   Synchronous, loadable, multi-digit BCD down-counter/timer. Complements the ripple mod-10 up-counter.
//   Counts a preset BCD value down to zero on qualified ticks and flags terminal count.
//   With AUTO_RELOAD=1 it behaves as a programmable mod-(N+1) down counter (preset 9 -> mod-10).
//   Sits beside the up-counter path in timing/sequencing logic; all flops clocked on rising clk.
// PARAMETERS
//   DIGITS       2   number of BCD digits; count width is 4*DIGITS
//   AUTO_RELOAD  0   1: reload preset and keep running after reaching 0; 0: stop in DONE
// PORTS
//   clk       in   1          rising-edge clock
//   rst       in   1          reset, asynchronous, active-low
//   load      in   1          capture load_val into cnt and preset register
//   load_val  in   4*DIGITS   BCD preset, digit 0 in [3:0]
//   start     in   1          begin/resume counting
//   stop      in   1          pause counting, hold cnt
//   tick      in   1          count qualifier; one decrement per cycle with tick=1 in RUN
//   cnt       out  4*DIGITS   current BCD count
//   zero      out  1          cnt == 0 (combinational from cnt)
//   done      out  1          1-cycle pulse, terminal count reached
//   busy      out  1          state == RUN
//   err       out  1          1-cycle pulse, load_val had a digit > 9
// BEHAVIOUR
//   Reset (rst=0, async): cnt=0, preset=0, state=IDLE, done=0, err=0, busy=0; zero=1.
//   States: IDLE, RUN, DONE. Per-cycle priority: load > stop > start > tick.
//   load (any state): cnt<=load_val, preset<=load_val, next state IDLE. Digits >9 clamp to 9 in
//     both cnt and preset; err=1 the next cycle. Any start/stop/tick in the same cycle is ignored.
//   stop: RUN->IDLE, cnt held. stop in IDLE/DONE has no effect.
//   start in IDLE: if cnt!=0 -> RUN (cnt unchanged). If cnt==0 and preset!=0 -> cnt<=preset, RUN.
//     If both are 0, start is ignored.
//   start in DONE: if preset!=0 -> cnt<=preset, RUN. Otherwise stay in DONE.
//   start in RUN has no effect. tick outside RUN has no effect.
//   RUN with tick=1 and cnt!=0: BCD decrement. Digit 0 -> 9 with a borrow into the next digit.
//     The borrow ripples through consecutive zero digits within the same cycle (0x100 -> 0x099).
//   The tick that moves cnt 1 -> 0 asserts done=1 in the cycle cnt first reads 0 (registered together).
//     AUTO_RELOAD=0: state -> DONE in that same transition; busy drops with done.
//     AUTO_RELOAD=1: stay in RUN. The next tick with cnt==0 loads cnt<=preset (no done on reload).
//       Period is preset+1 ticks. If preset==0, go to DONE instead.
//   done and err are never asserted for more than one cycle per event.
//   Latency: cnt updates the cycle after the qualifying input; zero follows cnt combinationally.
//   Reset asserted mid-RUN forces the reset values immediately; preset is lost.
// TESTING
//   1. Reset mid-RUN at cnt=0x37: cnt=0x00, busy=0, done=0, zero=1 immediately; start is ignored afterwards.
//   2. DIGITS=2, load 0x25, start, 25 ticks -> cnt 0x24..0x20, 0x19 (borrow)...0x00.
//      done=1 for one cycle with cnt=0x00; busy=0; state DONE; further ticks leave cnt=0x00.
//   3. AUTO_RELOAD=1, load 0x09, start, tick every cycle -> cnt 9,8..0,9,8..
//      done pulses every 10 ticks, exactly on the 0 value.
//   4. load 0x3A -> cnt=0x39, err=1 for one cycle; load 0xF0 -> cnt=0x90, err=1.
//   5. RUN at 0x12: stop+tick -> cnt holds 0x12, busy=0; start -> RUN; tick -> 0x11.
//      load 0x50 with start in the same cycle -> cnt=0x50, state IDLE.
//   6. DONE after preset 0x03: start -> cnt=0x03, RUN. DIGITS=3, cnt=0x100, tick -> 0x099.
//      Preset 0x00, start -> ignored, busy stays 0.

Source files
------------

// File: rtl/bcd_down_timer.sv
// bcd_down_timer
//   Loadable multi-digit BCD down-counter/timer. A preset is loaded, counted
//   down to zero on qualified ticks, and terminal count is flagged with a
//   one-cycle done pulse. With AUTO_RELOAD=1 the preset is reloaded on the
//   tick after zero, giving a programmable mod-(preset+1) counter.
//
// Ports
//   clk       in   1         rising-edge clock
//   rst       in   1         asynchronous, active-low reset
//   load      in   1         capture load_val into cnt and preset (digits > 9 clamp to 9)
//   load_val  in   4*DIGITS  BCD preset, digit 0 in [3:0]
//   start     in   1         begin/resume counting
//   stop      in   1         pause counting, hold cnt
//   tick      in   1         count qualifier, one decrement per tick while running
//   cnt       out  4*DIGITS  current BCD count
//   zero      out  1         cnt == 0
//   done      out  1         one-cycle pulse when cnt reaches 0
//   busy      out  1         counter is running
//   err       out  1         one-cycle pulse, last load_val had a digit > 9
module bcd_down_timer #(
   parameter int DIGITS      = 2,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                start,
   input  logic                stop,
   input  logic                tick,
   output logic [4*DIGITS-1:0] cnt,
   output logic                zero,
   output logic                done,
   output logic                busy,
   output logic                err
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   preset, preset_nxt;
   logic [W-1:0]   cnt_nxt;
   logic           done_nxt, err_nxt;
   logic [W-1:0]   load_clamped;
   logic           load_bad;
   logic [W-1:0]   cnt_dec;

   // Replace any non-BCD digit with 9 so cnt/preset always hold legal BCD.
   function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic [3:0]   d;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
      end
      return r;
   endfunction

   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // BCD decrement: a zero digit becomes 9 and passes the borrow upward, so
   // a run of zero digits all wrap in the same cycle (0x100 -> 0x099).
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic [3:0]   d;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = d - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign load_clamped = clamp_bcd(load_val);
   assign load_bad     = has_bad_digit(load_val);
   assign cnt_dec      = bcd_dec(cnt);

   // NOTE: every registered value is assigned with <= so all flops sample the
   // same pre-edge values; blocking assignments here would create ordering races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         preset <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         preset <= preset_nxt;
         done   <= done_nxt;
         err    <= err_nxt;
      end
   end

   // Priority: load > stop > start > tick.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; a missed
      // branch would otherwise infer a latch.
      state_nxt  = state;
      cnt_nxt    = cnt;
      preset_nxt = preset;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;

      if (load) begin
         cnt_nxt    = load_clamped;
         preset_nxt = load_clamped;
         err_nxt    = load_bad;
         state_nxt  = IDLE;
      end else if (stop) begin
         if (state == RUN) state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (cnt != '0) begin
                     state_nxt = RUN;
                  end else if (preset != '0) begin
                     cnt_nxt   = preset;
                     state_nxt = RUN;
                  end
               end
            end
            DONE: begin
               if (start && preset != '0) begin
                  cnt_nxt   = preset;
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (tick) begin
                  if (cnt != '0) begin
                     cnt_nxt = cnt_dec;
                     // done is registered alongside the 1 -> 0 step so it
                     // coincides with the first cycle cnt reads zero.
                     if (cnt_dec == '0) begin
                        done_nxt = 1'b1;
                        if (!AUTO_RELOAD) state_nxt = DONE;
                     end
                  end else if (AUTO_RELOAD && preset != '0) begin
                     cnt_nxt = preset;
                  end else begin
                     state_nxt = DONE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign zero = (cnt == '0);
   assign busy = (state == RUN);

endmodule
